// File: rtl/spi_rom_responder.sv
// spi_rom_responder: SPI/QSPI flash-ROM stand-in answering 03h (single) and 6Bh (quad output) reads
// from an external one-cycle-latency byte memory, one SPI bit slot per clk cycle.
module spi_rom_responder #(
  parameter int MEM_ADDR_W = 24,
  parameter int QUAD_DUMMY = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_cs,
  input  logic                  spi_in0,
  output logic [3:0]            spi_out,
  output logic [3:0]            spi_oe,
  output logic                  mem_rd,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [7:0]            mem_data
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
  state_t state, state_nxt;
  logic prev_cs, quad, start, cmd_last, addr_last, dummy_last, fetch;
  logic [7:0] cnt, cmd, cmd_in, sh;
  logic [2:0] b;
  logic [23:0] ash, addr_q, fetch_addr;
  always_comb begin
    start = spi_cs && !prev_cs;
    cmd_in = {cmd[6:0], spi_in0};
    cmd_last = state == CMD && cnt == 8'd7;
    addr_last = state == ADDR && cnt == 8'd23;
    dummy_last = state == DUMMY && cnt == 8'(QUAD_DUMMY - 1);
    fetch = (addr_last && (!quad || QUAD_DUMMY == 0)) || dummy_last ||
            (state == DATA && (quad ? b[0] : b == 3'd7));
    // first fetch uses the freshly shifted address; later ones walk forward from the last fetch
    fetch_addr = state == DATA ? addr_q + 24'd1 : state == ADDR ? {ash[22:0], spi_in0} : ash;
    mem_rd = fetch;
    mem_addr = fetch ? fetch_addr[MEM_ADDR_W-1:0] : addr_q[MEM_ADDR_W-1:0];
    spi_oe = (state == DATA && spi_cs) ? (quad ? 4'hF : 4'b0010) : 4'h0;
    spi_out = state != DATA ? 4'h0 :
              quad ? (b[0] ? sh[7:4] : mem_data[7:4]) :
              {2'b00, b == 3'd0 ? mem_data[7] : sh[7], 1'b0};
    state_nxt = state;
    if (!spi_cs) state_nxt = IDLE;
    else if (state == IDLE && start) state_nxt = CMD;
    else if (cmd_last) state_nxt = (cmd_in == 8'h03 || cmd_in == 8'h6B) ? ADDR : IGNORE;
    else if (addr_last) state_nxt = (quad && QUAD_DUMMY > 0) ? DUMMY : DATA;
    else if (dummy_last) state_nxt = DATA;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      prev_cs <= 1'b1;
      quad <= 1'b0;
      cnt <= 8'd0;
      cmd <= 8'd0;
      ash <= 24'd0;
      addr_q <= 24'd0;
      b <= 3'd0;
      sh <= 8'd0;
    end else begin
      state <= state_nxt;
      prev_cs <= spi_cs;
      cnt <= (state_nxt != state) ? (state == IDLE ? 8'd1 : 8'd0) : cnt + 8'd1;
      if (state == IDLE || state == CMD) cmd <= cmd_in;
      if (cmd_last) quad <= cmd_in == 8'h6B;
      if (state == ADDR) ash <= {ash[22:0], spi_in0};
      if (fetch) addr_q <= fetch_addr;
      b <= state == DATA ? b + 3'd1 : 3'd0;
      if (state == DATA)
        sh <= quad ? (b[0] ? sh : {mem_data[3:0], 4'h0}) :
              (b == 3'd0 ? {mem_data[6:0], 1'b0} : sh << 1);
    end
  end
endmodule

// File: tb/tb_spi_rom_responder.sv
// tb_spi_rom_responder: directed transactions; fetched bytes are queued and matched against streamed data.
module tb_spi_rom_responder;
  localparam int QD = 8;
  logic clk = 1'b0, reset_n = 1'b0, spi_cs = 1'b0, spi_in0 = 1'b0;
  logic [3:0] spi_out, spi_oe;
  logic mem_rd;
  logic [23:0] mem_addr;
  logic [7:0] mem_data = 8'd0;
  int vectors = 0, miscompares = 0;
  logic [7:0] ovr [int];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  spi_rom_responder #(.MEM_ADDR_W(24), .QUAD_DUMMY(QD)) dut (
    .clk(clk), .reset_n(reset_n), .spi_cs(spi_cs), .spi_in0(spi_in0),
    .spi_out(spi_out), .spi_oe(spi_oe), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  function automatic logic [7:0] memv(logic [23:0] a);
    return ovr.exists(int'(a)) ? ovr[int'(a)] : (a[7:0] ^ a[15:8] ^ 8'h96);
  endfunction

  always @(posedge clk) if (mem_rd) mem_data <= memv(mem_addr);

  task automatic check(string tag, logic [23:0] obs, logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      spi_cs = 1'b0;
      spi_in0 = 1'b0;
      #1 check("idle_oe", 24'(spi_oe), 24'd0);
    end
  endtask

  task automatic run(logic [7:0] cmd, logic [23:0] addr, int n, int drop = -1, int rst_at = -1);
    bit known, q, fe;
    int ds, per;
    logic [7:0] acc;
    logic [23:0] fa;
    logic [31:0] word;
    known = cmd == 8'h03 || cmd == 8'h6B;
    q = cmd == 8'h6B;
    ds = q ? 32 + QD : 32;
    per = q ? 2 : 8;
    acc = 8'd0;
    word = {cmd, addr};
    exp_q.delete();
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      spi_cs = (s != drop);
      spi_in0 = s < 32 ? word[31-s] : 1'b0;
      if (s == rst_at) reset_n = 1'b0;
      #1;
      if (s == drop) begin
        check("drop_oe", 24'(spi_oe), 24'd0);
        return;
      end
      if (s == rst_at) begin
        check("rst_oe", 24'(spi_oe), 24'd0);
        check("rst_out", 24'(spi_out), 24'd0);
        check("rst_rd", 24'(mem_rd), 24'd0);
        return;
      end
      check($sformatf("oe_s%0d", s), 24'(spi_oe), 24'((known && s >= ds) ? (q ? 4'hF : 4'h2) : 4'h0));
      fe = known && s >= ds - 1 && ((s - ds + 1) % per == 0);
      check($sformatf("rd_s%0d", s), 24'(mem_rd), 24'(fe));
      if (fe) begin
        fa = addr + 24'((s - ds + 1) / per);
        check($sformatf("addr_s%0d", s), mem_addr, fa);
        exp_q.push_back(memv(fa));
      end
      if (known && s >= ds) begin
        acc = q ? {acc[3:0], spi_out} : {acc[6:0], spi_out[1]};
        if ((s - ds) % per == per - 1) begin
          if (exp_q.size() == 0) check("byte_underflow", 24'd1, 24'd0);
          else check($sformatf("byte_s%0d", s), 24'(acc), 24'(exp_q.pop_front()));
        end
      end
    end
  endtask

  initial begin
    ovr[32'h10] = 8'hA5;
    ovr[32'h11] = 8'h3C;
    ovr[32'h1040] = 8'hC3;
    ovr[32'h1041] = 8'h5E;
    ovr[32'hFFFFFF] = 8'h81;
    ovr[32'h0] = 8'h7E;
    ovr[32'h20] = 8'hD2;
    #2;
    check("reset_oe", 24'(spi_oe), 24'd0);
    check("reset_out", 24'(spi_out), 24'd0);
    check("reset_rd", 24'(mem_rd), 24'd0);
    check("reset_addr", mem_addr, 24'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    run(8'h03, 24'h000010, 48);
    idle(1);
    run(8'h6B, 24'h001040, 44);
    idle(1);
    run(8'h9F, 24'h000000, 60);
    idle(1);
    run(8'h03, 24'h000011, 40);
    idle(1);
    run(8'h03, 24'hFFFFFF, 48);
    idle(1);
    run(8'h03, 24'h000010, 37, 36);
    run(8'h03, 24'h000020, 48);
    idle(1);
    run(8'h6B, 24'h000100, 60, -1, 45);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reset_n = 1'b1;
      spi_cs = 1'b1;
      #1;
      check("post_rst_oe", 24'(spi_oe), 24'd0);
      check("post_rst_rd", 24'(mem_rd), 24'd0);
    end
    idle(1);
    run(8'h6B, 24'h001040, 44);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_rom_responder.md
# spi_rom_responder

Synthesizable SPI/QSPI flash-ROM responder: the chip-side counterpart of our VGA SPI-ROM reader. It decodes Read (03h) and Quad Output Fast Read (6Bh) transactions and streams bytes from an external synchronous byte memory onto io[1] (single) or io[3:0] (quad). It runs in the reader's `clk` domain at one SPI bit slot per `clk` cycle, so it can sit beside the reader in simulation and on FPGA test builds in place of a physical flash chip.

## Interface
Parameters:
- `MEM_ADDR_W`, 24: width of `mem_addr`; the low `MEM_ADDR_W` bits of the 24-bit SPI address are used.
- `QUAD_DUMMY`, 8: dummy slots between the address and the first quad data nibble.

Ports:
- `clk`  in  1  system clock; SPI SCLK is `~clk`, so one bit slot is one `clk` cycle.
- `reset_n`  in  1  **asynchronous, active-low reset**.
- `spi_cs`  in  1  chip select, **active high**.
- `spi_in0`  in  1  io[0] from the controller (MOSI).
- `spi_out`  out  4  io[3:0] output values.
- `spi_oe`  out  4  io[3:0] output enables (1 = responder drives).
- `mem_rd`  out  1  memory read strobe.
- `mem_addr`  out  MEM_ADDR_W  memory byte address.
- `mem_data`  in  8  byte read from memory, valid in the cycle after `mem_rd`.

## Operation
- Slot n is the n-th consecutive cycle with `spi_cs`=1, counted from 0. The value on `spi_in0` during slot n is captured at the `clk` edge that ends slot n.
- A transaction starts only on a slot 0, which is a cycle with `spi_cs`=1 that follows a sampled `spi_cs`=0. After reset the previous `spi_cs` is treated as 1.
- FSM states: IDLE, CMD (slots 0–7, MSB first), ADDR (slots 8–31, A[23] first), DUMMY (quad only), DATA, IGNORE.
- IDLE → CMD on slot 0.
- CMD → ADDR after slot 7 if the command is 03h or 6Bh, else → IGNORE.
- ADDR → DATA (03h) or → DUMMY (6Bh) after slot 31.
- DUMMY → DATA after `QUAD_DUMMY` slots.
- Any state → IDLE on the edge where `spi_cs` is sampled 0.
- Single read (03h), byte k:
  - Fetch address is A+k mod 2^24.
  - Fetch is issued in slot 31+8k. `mem_rd`=1 and `mem_addr` = that address. In slot 31, `mem_addr` = {addr_shift[22:0], `spi_in0`} combinationally.
  - `spi_out[1]` = `mem_data[7]` in slot 32+8k. Bits 6..0 come from an internal shift register in slots 33+8k..39+8k.
  - `spi_oe` = 4'b0010 from slot 32 onward.
- Quad read (6Bh), byte k:
  - Fetch is issued in slot 31+QUAD_DUMMY+2k.
  - High nibble `mem_data[7:4]` is on `spi_out` in slot 32+QUAD_DUMMY+2k. Low nibble (registered) is on `spi_out` in the next slot.
  - `spi_oe` = 4'hF from slot 32+QUAD_DUMMY onward.
  - `spi_oe[0]` is 0 in all slots below 32+QUAD_DUMMY, so there is no contention with the controller's io[0].
- The streamed length is unbounded. Fetches continue every 8 slots (single) or every 2 slots (quad) until `spi_cs` falls. The address counter wraps 24'hFFFFFF → 24'h000000.
- Unknown command: IGNORE state, `spi_oe`=0 and `mem_rd`=0 until `spi_cs`=0.

## Timing
- Reset values: `spi_out`=0, `spi_oe`=0, `mem_rd`=0, `mem_addr`=0, state IDLE, previous-cs flag = 1. Reset is asynchronous: assertion clears all outputs immediately, mid-transaction included.
- `spi_oe` is gated combinationally by `spi_cs`, so `spi_cs`=0 forces `spi_oe`=0 in the same cycle.
- The only input→output combinational paths allowed are `spi_cs`→`spi_oe` and, in slot 31, `spi_in0`→`mem_addr`. `spi_out` is driven only from registers and `mem_data`.
- `mem_rd` is a single-cycle pulse per byte. `mem_addr` holds its value between pulses.
- Memory latency is exactly 1 cycle. There are no stalls or backpressure.
- If `spi_cs` falls in the same cycle as a fetch, the returned `mem_data` is ignored.
- If `spi_cs` rises in the cycle immediately after it falls, that cycle is slot 0 of a new transaction.

## Test plan
- **03h at 0x000010**, memory[0x10]=A5h, [0x11]=3Ch:
  - `spi_out[1]` over slots 32–47 = 1010_0101_0011_1100.
  - `mem_rd` pulses in slots 31 and 39 with `mem_addr` 0x10 then 0x11.
- **6Bh at 0x001040**, [0x1040]=C3h, [0x1041]=5Eh:
  - `spi_oe`=0 in slots 0–39.
  - `spi_out` in slots 40–43 = C, 3, 5, E.
  - `spi_oe`=F from slot 40.
- **Command 9Fh, cs held 60 slots**: `spi_oe`=0 and `mem_rd`=0 throughout. A following 03h transaction reads correctly.
- **03h at 0xFFFFFF**, 16 data slots: the second fetch uses `mem_addr`=0x000000 (with `MEM_ADDR_W`=24).
- **`spi_cs` dropped in slot 36 of a 03h read**: `spi_oe`=0 in that same cycle. An immediate new 03h read at 0x000020 returns memory[0x20] starting at its slot 32.
- **`reset_n` asserted in slot 45 of a quad read**:
  - `spi_oe`=0 and `spi_out`=0 at once.
  - `reset_n` is released while `spi_cs` is still 1: `spi_oe` stays 0 until `spi_cs` goes low.
  - The next transaction then works normally.
